mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255, giving the maximum cycles to wait for mem_ack before abort.
REQ-002 The block SHALL have parameter DATA_FIRST, default 1'b1, selecting data over instruction when both request in IDLE.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 n_reset  input  1  reset, asynchronous and active-low.
REQ-005 inst_read_enable  input  1  instruction fetch request, held until inst_ready.
REQ-006 inst_address  input  32  fetch address.
REQ-007 inst_read_data  output  32  fetch data, valid when inst_ready=1.
REQ-008 inst_ready  output  1  one-cycle completion strobe for the instruction port.
REQ-009 data_read_enable, data_write_enable  input  1 each  data request, held until data_ready; both high is illegal.
REQ-010 data_address  input  32; data_size  input  enums_pkg::mem_size_t; data_write_data  input  32.
REQ-011 data_read_data  output  32  load data, valid when data_ready=1.
REQ-012 data_ready  output  1  one-cycle completion strobe for the data port.
REQ-013 mem_address  output  32; mem_size  output  mem_size_t; mem_write_data  output  32; mem_read_enable, mem_write_enable  output  1 each  shared memory bus.
REQ-014 mem_read_data  input  32; mem_ack  input  1  one-cycle completion from memory, at least 1 cycle after request.
REQ-015 stall  output  1  high while any port request is asserted and its ready is low.
REQ-016 bus_error  output  1  one-cycle strobe on transaction timeout.

Function
REQ-017 The FSM SHALL have states IDLE, GRANT_INST, GRANT_DATA.
REQ-018 In IDLE with one port requesting, the FSM SHALL enter that port's GRANT state next cycle; with both requesting, GRANT_DATA if DATA_FIRST else GRANT_INST.
REQ-019 mem_* outputs SHALL be driven only from registered grant state: in GRANT_x they mirror port x's address/size/enables/write data; in IDLE all mem enables are 0 and address/data are 0.
REQ-020 Minimum latency: request in cycle N, mem enable high in cycle N+1, ready in the cycle mem_ack is sampled high.
REQ-021 In GRANT_x, inst_ready/data_ready for port x SHALL equal mem_ack combinationally, and the matching read_data output SHALL equal mem_read_data; non-granted ready is 0.
REQ-022 On the ack cycle, the completing port SHALL be treated as not requesting; if the other port requests, the FSM SHALL go directly to its GRANT state (no IDLE bubble), else to IDLE.
REQ-023 A port SHALL therefore never receive two consecutive grants while the other port is waiting (strict alternation under contention).
REQ-024 A wait counter SHALL reset to 0 on entering any GRANT state and increment each GRANT cycle without mem_ack; upon reaching TIMEOUT_CYCLES, bus_error SHALL pulse, the granted port's ready SHALL pulse with read_data 0, and the FSM SHALL follow REQ-022.
REQ-025 Requests dropped mid-grant are protocol violations; the FSM SHALL hold the grant until mem_ack or timeout regardless.
REQ-026 mem_ack in IDLE SHALL be ignored.
REQ-027 stall SHALL be combinational: (inst_read_enable & ~inst_ready) | ((data_read_enable|data_write_enable) & ~data_ready).

Reset
REQ-028 While n_reset=0: state IDLE, wait counter 0, all mem enables 0, inst_ready=data_ready=bus_error=0, read data outputs 0.
REQ-029 Reset asserted mid-grant SHALL abort the transaction immediately with no ready strobe; first grant after release follows REQ-018.

Structure
REQ-030 arbiter_pkg SHALL hold the state enum arb_state_t; mem_size_t stays in enums_pkg.
REQ-031 The block SHALL be a single module; no sub-module.

Verification
REQ-032 Inst read 0x0000_0010, mem_ack 1 cycle after mem_read_enable, mem_read_data 0x0000_0513 -> inst_ready one cycle, inst_read_data 0x0000_0513, stall high 2 cycles.
REQ-033 Both ports request in the same cycle (data write 0xDEAD_BEEF to 0x100, size word) -> data granted first, then inst with no IDLE cycle between.
REQ-034 Data port requests continuously with inst pending -> grants alternate D,I,D,I over 8 transactions.
REQ-035 TIMEOUT_CYCLES=4, mem_ack never asserted -> bus_error and data_ready pulse after 4 grant cycles, data_read_data 0, FSM returns to IDLE.
REQ-036 n_reset low during GRANT_INST with ack pending -> mem enables 0 within reset, no inst_ready; after release, new fetch completes normally.
REQ-037 mem_ack pulse while IDLE -> no ready strobe, state unchanged.

Source files
------------

// File: rtl/arbiter_pkg.sv
// ---------------------------------------------------------------------------
// arbiter_pkg
//   Types private to the memory arbiter.
//   arb_state_t : grant state of mem_arbiter (idle, instruction, data).
// ---------------------------------------------------------------------------
package arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    GRANT_INST = 2'd1,
    GRANT_DATA = 2'd2
  } arb_state_t;

endpackage : arbiter_pkg

// File: rtl/enums_pkg.sv
// ---------------------------------------------------------------------------
// enums_pkg
//   Memory-bus enumerations shared across the codebase.
//   mem_size_t : access width on the data port and on the shared memory bus.
// ---------------------------------------------------------------------------
package enums_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } mem_size_t;

endpackage : enums_pkg

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Two-port (instruction fetch / data load-store) arbiter onto one shared
//   memory bus. One transaction is outstanding at a time. Ties from idle go
//   to the port selected by DATA_FIRST; under contention the ports strictly
//   alternate because the completing port never competes on its ack cycle.
//   A transaction not acknowledged within TIMEOUT_CYCLES is aborted with a
//   bus_error strobe and a ready strobe carrying zero read data.
//
// Parameters
//   TIMEOUT_CYCLES : unacknowledged grant cycles tolerated before abort
//   DATA_FIRST     : 1 = data port wins a simultaneous request from idle
//
// Ports
//   clock, n_reset                  : clock, asynchronous active-low reset
//   inst_read_enable, inst_address  : fetch request (held until inst_ready)
//   inst_read_data, inst_ready      : fetch data and one-cycle completion
//   data_read_enable, data_write_enable, data_address, data_size,
//   data_write_data                 : load/store request (held until data_ready)
//   data_read_data, data_ready      : load data and one-cycle completion
//   mem_address, mem_size, mem_write_data,
//   mem_read_enable, mem_write_enable : shared memory bus request
//   mem_read_data, mem_ack          : memory response
//   stall                           : a port is requesting and not yet ready
//   bus_error                       : one-cycle strobe on transaction timeout
// ---------------------------------------------------------------------------
module mem_arbiter
  import enums_pkg::*;
  import arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic        DATA_FIRST     = 1'b1
) (
  input  logic        clock,
  input  logic        n_reset,

  input  logic        inst_read_enable,
  input  logic [31:0] inst_address,
  output logic [31:0] inst_read_data,
  output logic        inst_ready,

  input  logic        data_read_enable,
  input  logic        data_write_enable,
  input  logic [31:0] data_address,
  input  mem_size_t   data_size,
  input  logic [31:0] data_write_data,
  output logic [31:0] data_read_data,
  output logic        data_ready,

  output logic [31:0] mem_address,
  output mem_size_t   mem_size,
  output logic [31:0] mem_write_data,
  output logic        mem_read_enable,
  output logic        mem_write_enable,
  input  logic [31:0] mem_read_data,
  input  logic        mem_ack,

  output logic        stall,
  output logic        bus_error
);

  // Counter must be able to hold TIMEOUT_CYCLES itself.
  localparam int unsigned CNT_W =
    (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  arb_state_t       state;
  arb_state_t       state_next;
  logic [CNT_W-1:0] wait_cnt;

  logic inst_req;
  logic data_req;
  logic granted;
  logic timeout;
  logic done;

  assign inst_req = inst_read_enable;
  assign data_req = data_read_enable | data_write_enable;

  // Completion is either a real ack or the abort on the cycle the counter
  // has reached the limit; an ack on that same cycle still wins.
  assign granted = (state != IDLE);
  assign timeout = granted & ~mem_ack & (wait_cnt == WAIT_LIMIT);
  assign done    = granted & (mem_ack | timeout);

  assign stall = (inst_req & ~inst_ready) | (data_req & ~data_ready);

  // -------------------------------------------------------------------------
  // State register and wait counter
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state <= state_next;
      // Cleared whenever the next cycle starts a fresh grant (from idle or
      // straight after a completion), counted up while a grant is waiting.
      if (!granted || done) begin
        wait_cnt <= '0;
      end else begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Next state
  // On a completion the finishing port is ignored, so the other port is
  // granted with no idle bubble if it is waiting.
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (inst_req && data_req) begin
          state_next = DATA_FIRST ? GRANT_DATA : GRANT_INST;
        end else if (data_req) begin
          state_next = GRANT_DATA;
        end else if (inst_req) begin
          state_next = GRANT_INST;
        end
      end
      GRANT_INST: begin
        if (done) begin
          state_next = data_req ? GRANT_DATA : IDLE;
        end
      end
      GRANT_DATA: begin
        if (done) begin
          state_next = inst_req ? GRANT_INST : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Bus and port outputs, selected only by the registered grant state.
  // mem_ack in IDLE has no effect because every response path is gated by
  // the grant.
  // -------------------------------------------------------------------------
  always_comb begin
    mem_address      = '0;
    mem_size         = SIZE_BYTE;
    mem_write_data   = '0;
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    inst_ready       = 1'b0;
    inst_read_data   = '0;
    data_ready       = 1'b0;
    data_read_data   = '0;
    bus_error        = 1'b0;

    unique case (state)
      GRANT_INST: begin
        mem_address     = inst_address;
        mem_size        = SIZE_WORD;
        mem_read_enable = inst_read_enable;
        inst_ready      = done;
        inst_read_data  = timeout ? '0 : mem_read_data;
        bus_error       = timeout;
      end
      GRANT_DATA: begin
        mem_address      = data_address;
        mem_size         = data_size;
        mem_write_data   = data_write_data;
        mem_read_enable  = data_read_enable;
        mem_write_enable = data_write_enable;
        data_ready       = done;
        data_read_data   = timeout ? '0 : mem_read_data;
        bus_error        = timeout;
      end
      default: begin
      end
    endcase
  end

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter. Port drivers push the expected
//   completion data into per-port queues when they issue a request; a monitor
//   on the falling edge pops and compares on every ready strobe and checks
//   the bus, strobes and stall every cycle against the arbitration rules.
//   A behavioural memory answers bus requests after a random delay.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;
  import enums_pkg::*;

  localparam int unsigned TMO    = 4;
  localparam logic        DFIRST = 1'b1;

  logic        clock = 1'b0;
  logic        n_reset = 1'b0;
  logic        inst_read_enable = 1'b0;
  logic [31:0] inst_address = '0;
  logic [31:0] inst_read_data;
  logic        inst_ready;
  logic        data_read_enable = 1'b0;
  logic        data_write_enable = 1'b0;
  logic [31:0] data_address = '0;
  mem_size_t   data_size = SIZE_BYTE;
  logic [31:0] data_write_data = '0;
  logic [31:0] data_read_data;
  logic        data_ready;
  logic [31:0] mem_address;
  mem_size_t   mem_size;
  logic [31:0] mem_write_data;
  logic        mem_read_enable;
  logic        mem_write_enable;
  logic [31:0] mem_read_data = '0;
  logic        mem_ack = 1'b0;
  logic        stall;
  logic        bus_error;

  mem_arbiter #(.TIMEOUT_CYCLES(TMO), .DATA_FIRST(DFIRST)) dut (
    .clock(clock), .n_reset(n_reset),
    .inst_read_enable(inst_read_enable), .inst_address(inst_address),
    .inst_read_data(inst_read_data), .inst_ready(inst_ready),
    .data_read_enable(data_read_enable), .data_write_enable(data_write_enable),
    .data_address(data_address), .data_size(data_size),
    .data_write_data(data_write_data), .data_read_data(data_read_data),
    .data_ready(data_ready),
    .mem_address(mem_address), .mem_size(mem_size),
    .mem_write_data(mem_write_data), .mem_read_enable(mem_read_enable),
    .mem_write_enable(mem_write_enable), .mem_read_data(mem_read_data),
    .mem_ack(mem_ack), .stall(stall), .bus_error(bus_error)
  );

  always #5 clock = ~clock;

  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory contents: reference view and responder view ----
  logic [31:0] ref_mem   [logic [31:0]];
  logic [31:0] mem_store [logic [31:0]];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h3C5A, ~a[15:0]};
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem_store.exists(a) ? mem_store[a] : init_word(a);
  endfunction

  // ---------------- scoreboard queues and observation log -----------------
  typedef struct { logic is_read; logic [31:0] val; } dexp_t;
  typedef struct { int unsigned port; logic gap; } done_t;  // port 1=inst 2=data

  logic [31:0] inst_q[$];
  dexp_t       data_q[$];
  done_t       done_log[$];

  // ---------------- behavioural memory responder --------------------------
  logic        no_ack = 1'b0;
  logic        force_ack = 1'b0;
  int unsigned fixed_delay = 0;
  logic        done_last = 1'b0;
  int unsigned rcyc = 0;
  int unsigned rdly = 1;

  always begin
    @(posedge clock);
    #2;
    if (!n_reset || done_last || !(mem_read_enable | mem_write_enable)) rcyc = 0;
    if (n_reset && (mem_read_enable | mem_write_enable)) begin
      rcyc++;
      if (rcyc == 1) rdly = (fixed_delay != 0) ? fixed_delay : $urandom_range(3, 1);
    end
    mem_ack = force_ack || (rcyc != 0 && !no_ack && rcyc == rdly + 1);
    mem_read_data = (rcyc != 0 && mem_read_enable) ? mem_rd(mem_address) : $urandom;
  end

  always @(negedge clock) begin
    done_last = inst_ready | data_ready;
    if (n_reset && mem_ack && mem_write_enable) mem_store[mem_address] = mem_write_data;
  end

  // ---------------- monitor / checker -------------------------------------
  int unsigned own = 0;       // expected grant holder this cycle: 0/1 inst/2 data
  int unsigned gcyc = 0;      // 1-based cycle index within the current grant
  int unsigned stall_cnt = 0;
  int unsigned en_run = 0;
  int unsigned last_en_run = 0;
  int unsigned err_cnt = 0;
  int unsigned iready_cnt = 0;
  int unsigned dready_cnt = 0;
  logic        gap_seen = 1'b1;

  always @(negedge clock) begin : mon
    logic        ireq, dreq, exp_tmo, exp_done, e_re, e_we;
    logic [31:0] e_addr, e_wd, qv;
    mem_size_t   e_size;
    dexp_t       dq;
    int unsigned nxt;

    ireq = inst_read_enable;
    dreq = data_read_enable | data_write_enable;
    if (stall) stall_cnt++;
    if (inst_ready) iready_cnt++;
    if (data_ready) dready_cnt++;
    if (bus_error) err_cnt++;
    check32("stall", {31'b0, stall}, {31'b0, (ireq & ~inst_ready) | (dreq & ~data_ready)});

    if (!n_reset) begin
      check32("rst_strobes", {28'b0, mem_read_enable, mem_write_enable, inst_ready, data_ready}, '0);
      check32("rst_bus_error", {31'b0, bus_error}, '0);
      check32("rst_inst_read_data", inst_read_data, '0);
      check32("rst_data_read_data", data_read_data, '0);
      own = 0;
      gcyc = 0;
      en_run = 0;
    end else begin
      exp_tmo  = (own != 0) && !mem_ack && (gcyc == TMO + 1);
      exp_done = (own != 0) && (mem_ack || exp_tmo);

      e_addr = '0; e_wd = '0; e_size = SIZE_BYTE; e_re = 1'b0; e_we = 1'b0;
      if (own == 1) begin
        e_addr = inst_address; e_size = SIZE_WORD; e_re = inst_read_enable;
      end else if (own == 2) begin
        e_addr = data_address; e_size = data_size; e_wd = data_write_data;
        e_re = data_read_enable; e_we = data_write_enable;
      end
      check32("mem_address", mem_address, e_addr);
      check32("mem_ctrl", {28'b0, mem_size, mem_read_enable, mem_write_enable},
              {28'b0, e_size, e_re, e_we});
      check32("mem_write_data", mem_write_data, e_wd);
      check32("inst_ready", {31'b0, inst_ready}, {31'b0, own == 1 && exp_done});
      check32("data_ready", {31'b0, data_ready}, {31'b0, own == 2 && exp_done});
      check32("bus_error", {31'b0, bus_error}, {31'b0, exp_tmo});

      if (mem_read_enable | mem_write_enable) en_run++;
      else gap_seen = 1'b1;

      if (inst_ready) begin
        if (inst_q.size() == 0) begin
          check32("inst_unexpected_ready", 32'd1, 32'd0);
        end else begin
          qv = inst_q.pop_front();
          check32("inst_read_data", inst_read_data, qv);
        end
        done_log.push_back('{port: 1, gap: gap_seen});
      end
      if (data_ready) begin
        if (data_q.size() == 0) begin
          check32("data_unexpected_ready", 32'd1, 32'd0);
        end else begin
          dq = data_q.pop_front();
          if (dq.is_read) check32("data_read_data", data_read_data, dq.val);
        end
        done_log.push_back('{port: 2, gap: gap_seen});
      end
      if (inst_ready | data_ready) begin
        gap_seen = 1'b0;
        last_en_run = en_run;
        en_run = 0;
      end

      // Arbitration rule: idle ties go to DATA_FIRST's port; on completion
      // the other port is served if it waits, otherwise the bus goes idle.
      if (own == 0) begin
        if (ireq && dreq) nxt = DFIRST ? 2 : 1;
        else if (dreq)    nxt = 2;
        else if (ireq)    nxt = 1;
        else              nxt = 0;
      end else if (exp_done) begin
        if (own == 2) nxt = ireq ? 1 : 0;
        else          nxt = dreq ? 2 : 0;
      end else begin
        nxt = own;
      end
      if (nxt == 0)                      gcyc = 0;
      else if (own == 0 || exp_done)     gcyc = 1;
      else                               gcyc++;
      own = nxt;
    end
  end

  // ---------------- port drivers -------------------------------------------
  task automatic sync();
    @(posedge clock);
    #1;
  endtask

  task automatic inst_txn(input logic [31:0] addr);
    int unsigned n;
    inst_address = addr;
    inst_read_enable = 1'b1;
    inst_q.push_back(ref_read(addr));
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!inst_ready && n < 50);
    if (!inst_ready) check32("inst_wait_timeout", 32'd0, 32'd1);
    sync();
    inst_read_enable = 1'b0;
  endtask

  task automatic data_txn(input logic wr, input logic [31:0] addr, input mem_size_t sz,
                          input logic [31:0] wd, input logic tmo);
    int unsigned n;
    data_address = addr;
    data_size = sz;
    data_write_data = wd;
    data_write_enable = wr;
    data_read_enable = ~wr;
    if (wr) begin
      if (!tmo) ref_mem[addr] = wd;
      data_q.push_back('{is_read: 1'b0, val: '0});
    end else begin
      data_q.push_back('{is_read: 1'b1, val: tmo ? 32'h0 : ref_read(addr)});
    end
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!data_ready && n < 50);
    if (!data_ready) check32("data_wait_timeout", 32'd0, 32'd1);
    sync();
    data_read_enable = 1'b0;
    data_write_enable = 1'b0;
  endtask

  function automatic logic [31:0] rand_inst_addr();
    return {20'h0, 2'b00, 8'($urandom_range(255, 0)), 2'b00};
  endfunction

  function automatic logic [31:0] rand_data_addr();
    return 32'h1000 + 32'($urandom_range(63, 0)) * 4;
  endfunction

  // ---------------- stimulus sequence --------------------------------------
  int unsigned snap_i, snap_d, snap_e;

  initial begin
    repeat (3) @(posedge clock);
    #1;
    n_reset = 1'b1;
    sync();

    // Single fetch: 1-cycle memory latency, two stall cycles.
    ref_mem[32'h10] = 32'h0000_0513;
    mem_store[32'h10] = 32'h0000_0513;
    fixed_delay = 1;
    stall_cnt = 0;
    snap_i = iready_cnt;
    inst_txn(32'h0000_0010);
    check32("fetch_stall_cycles", stall_cnt, 32'd2);
    check32("fetch_ready_pulses", iready_cnt - snap_i, 32'd1);
    fixed_delay = 0;
    sync();

    // Simultaneous requests: data first, then inst without an idle cycle.
    done_log.delete();
    fork
      inst_txn(32'h0000_0020);
      data_txn(1'b1, 32'h0000_0100, SIZE_WORD, 32'hDEAD_BEEF, 1'b0);
    join
    check32("tie_count", done_log.size(), 32'd2);
    if (done_log.size() == 2) begin
      check32("tie_first_port", done_log[0].port, 32'd2);
      check32("tie_second_port", done_log[1].port, 32'd1);
      check32("tie_no_bubble", {31'b0, done_log[1].gap}, 32'd0);
    end
    data_txn(1'b0, 32'h0000_0100, SIZE_WORD, 32'h0, 1'b0);
    sync();

    // Continuous contention: strict alternation D,I,D,I...
    done_log.delete();
    fork
      repeat (4) data_txn(1'($urandom_range(1, 0)), rand_data_addr(),
                          mem_size_t'($urandom_range(2, 0)), $urandom, 1'b0);
      repeat (4) inst_txn(rand_inst_addr());
    join
    check32("alt_count", done_log.size(), 32'd8);
    for (int i = 0; i < done_log.size() && i < 8; i++)
      check32("alt_order", done_log[i].port, (i % 2 == 0) ? 32'd2 : 32'd1);
    sync();

    // Random traffic on both ports.
    fork
      repeat (30) begin
        repeat ($urandom_range(3, 0)) sync();
        inst_txn(rand_inst_addr());
      end
      repeat (30) begin
        repeat ($urandom_range(3, 0)) sync();
        data_txn(1'($urandom_range(1, 0)), rand_data_addr(),
                 mem_size_t'($urandom_range(2, 0)), $urandom, 1'b0);
      end
    join
    sync();

    // Timeout: four unacknowledged grant cycles, abort lands on the fifth.
    no_ack = 1'b1;
    snap_e = err_cnt;
    data_txn(1'b0, 32'h0000_1040, SIZE_WORD, 32'h0, 1'b1);
    check32("tmo_grant_cycles", last_en_run, TMO + 1);
    check32("tmo_bus_error_pulses", err_cnt - snap_e, 32'd1);
    @(negedge clock);
    check32("tmo_back_to_idle", {30'b0, mem_read_enable, mem_write_enable}, '0);
    sync();

    // Reset in the middle of a pending fetch.
    snap_i = iready_cnt;
    inst_address = 32'h0000_0040;
    inst_read_enable = 1'b1;
    repeat (3) sync();
    n_reset = 1'b0;
    #1;
    check32("rst_abort_enables", {30'b0, mem_read_enable, mem_write_enable}, '0);
    inst_read_enable = 1'b0;
    repeat (2) sync();
    n_reset = 1'b1;
    no_ack = 1'b0;
    repeat (2) sync();
    check32("rst_abort_no_ready", iready_cnt - snap_i, 32'd0);
    inst_txn(32'h0000_0044);
    sync();

    // Stray ack while idle.
    snap_i = iready_cnt;
    snap_d = dready_cnt;
    force_ack = 1'b1;
    sync();
    force_ack = 1'b0;
    sync();
    check32("idle_ack_no_ready", (iready_cnt - snap_i) + (dready_cnt - snap_d), 32'd0);
    check32("idle_ack_bus_idle", {30'b0, mem_read_enable, mem_write_enable}, '0);
    data_txn(1'b0, 32'h0000_1004, SIZE_HALF, 32'h0, 1'b0);
    repeat (2) sync();

    check32("inst_queue_drained", inst_q.size(), 32'd0);
    check32("data_queue_drained", data_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_mem_arbiter
